// File: rtl/vid2axis_packer_if.sv
// AXI4-Stream video beat bundle: 24-bit pixel with start-of-frame (tuser)
// and end-of-line (tlast) sidebands.
interface vid2axis_packer_if;
  logic [23:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tuser;
  logic        tlast;

  modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/vid2axis_packer.sv
// Packs a DE/VSYNC video stream into AXI4-Stream beats through a show-ahead
// FIFO; one-pixel stage lets end-of-line be tagged when DE falls.
module vid2axis_packer #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     vid_de,
  input  logic                     vid_vsync,
  input  logic [23:0]              pixel_in,
  vid2axis_packer_if.master        m_axis,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef struct packed {
    logic        last;
    logic        sof;
    logic [23:0] data;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [23:0]        stage_data;
  logic               stage_sof;
  logic               stage_valid;
  logic               sof_pending;

  logic   full;
  logic   push;
  logic   pop;
  logic   push_ok;
  entry_t push_entry;
  entry_t head;

  assign full       = (level == LVL_W'(DEPTH));
  assign push       = stage_valid;
  assign pop        = m_axis.tvalid && m_axis.tready;
  assign push_ok    = push && (!full || pop);
  // A staged pixel closes its line when no further pixel follows it.
  assign push_entry = '{last: !vid_de, sof: stage_sof, data: stage_data};

  // Valid comes from registered occupancy only, never from tready.
  assign m_axis.tvalid = (level != '0);
  assign head          = m_axis.tvalid ? mem[rd_ptr] : '0;
  assign m_axis.tdata  = head.data;
  assign m_axis.tuser  = head.sof;
  assign m_axis.tlast  = head.last;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values, regardless of the order of always_ff blocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_valid <= 1'b0;
      stage_sof   <= 1'b0;
      stage_data  <= '0;
      sof_pending <= 1'b0;
    end else begin
      stage_valid <= vid_de;
      if (vid_de) begin
        stage_data <= pixel_in;
        stage_sof  <= sof_pending || vid_vsync;
      end
      if (vid_vsync)
        sof_pending <= 1'b1;
      else if (vid_de)
        sof_pending <= 1'b0;
    end
  end

  // NOTE: storage is deliberately left out of reset; the outputs are gated by
  // tvalid, so stale contents are never visible and the array maps to RAM.
  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
      if (push && !push_ok)
        overflow <= 1'b1;
    end
  end

endmodule
